sdram_cmd_arbiter: RTL and testbench

- Parametrised SDRAM command/bus arbiter; successor to the single write/read-engine top-level arbiter.
- Multiplexes the init sequencer, the auto-refresh engine and NUM_CH client access engines (write or read bursts) onto a single SDRAM command/address/bank/DQ bus.
- Selectable fixed-priority or round-robin arbitration among clients; refresh always wins.
- Per-access watchdog timeout with a sticky error flag.

---
 rtl/sdram_cmd_arbiter_if.sv | 55 +++++
 rtl/sdram_cmd_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_sdram_cmd_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sdram_cmd_arbiter_if.sv
// Bundle between the SDRAM command arbiter and its init/refresh/client engines plus the pad-side bus.
// The slave modport is the arbiter's view; the master modport is the engines' and pads' view.
interface sdram_cmd_arbiter_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 13,
    parameter int BA_W   = 2,
    parameter int DQ_W   = 24
);
    logic                     init_end;
    logic [3:0]               init_cmd;
    logic [ADDR_W-1:0]        init_addr;

    logic                     ref_req;
    logic                     ref_en;
    logic                     ref_end;
    logic [3:0]               ref_cmd;
    logic [ADDR_W-1:0]        ref_addr;

    logic [NUM_CH-1:0]        ch_req;
    logic [NUM_CH-1:0]        ch_en;
    logic [NUM_CH-1:0]        ch_end;
    logic [4*NUM_CH-1:0]      ch_cmd;
    logic [ADDR_W*NUM_CH-1:0] ch_addr;
    logic [BA_W*NUM_CH-1:0]   ch_bank;
    logic [NUM_CH-1:0]        ch_dq_oe;
    logic [DQ_W*NUM_CH-1:0]   ch_dq;

    logic [3:0]               sd_cmd;
    logic [ADDR_W-1:0]        sd_addr;
    logic [BA_W-1:0]          sd_bank;
    logic [DQ_W-1:0]          sd_dq_out;
    logic                     sd_dq_oe;

    logic [2:0]               grant_id;
    logic                     busy;
    logic                     err_timeout;

    modport slave (
        input  init_end, init_cmd, init_addr,
        input  ref_req, ref_end, ref_cmd, ref_addr,
        input  ch_req, ch_end, ch_cmd, ch_addr, ch_bank, ch_dq_oe, ch_dq,
        output ref_en, ch_en,
        output sd_cmd, sd_addr, sd_bank, sd_dq_out, sd_dq_oe,
        output grant_id, busy, err_timeout
    );

    modport master (
        output init_end, init_cmd, init_addr,
        output ref_req, ref_end, ref_cmd, ref_addr,
        output ch_req, ch_end, ch_cmd, ch_addr, ch_bank, ch_dq_oe, ch_dq,
        input  ref_en, ch_en,
        input  sd_cmd, sd_addr, sd_bank, sd_dq_out, sd_dq_oe,
        input  grant_id, busy, err_timeout
    );
endinterface

// File: rtl/sdram_cmd_arbiter.sv
// SDRAM command/bus arbiter: muxes init, auto-refresh and NUM_CH burst engines onto one SDRAM bus.
// Refresh always wins; clients are served fixed-priority or round-robin, guarded by a watchdog.
module sdram_cmd_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int ADDR_W  = 13,
    parameter int BA_W    = 2,
    parameter int DQ_W    = 24,
    parameter int RR_EN   = 1,
    parameter int TIMEOUT = 1023
) (
    input  logic                 sclk,
    input  logic                 s_rst_n,
    sdram_cmd_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARBIT  = 2'd1,
        AREF   = 2'd2,
        ACCESS = 2'd3
    } state_t;

    localparam logic [3:0] CMD_NOP = 4'b0111;
    localparam int         TMR_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_t             state, next_state;
    logic               ref_en, ref_en_nxt;
    logic [NUM_CH-1:0]  ch_en, ch_en_nxt;
    logic [2:0]         grant_id, grant_nxt;
    logic [2:0]         rr_ptr, rr_ptr_nxt;
    logic [TMR_W-1:0]   timer;
    logic               err_timeout;
    logic               timeout_hit;
    logic               wd_expire;

    logic               win_found;
    logic [2:0]         win_idx;
    logic [2:0]         cand;

    logic [3:0]         sel_cmd;
    logic [ADDR_W-1:0]  sel_addr;
    logic [BA_W-1:0]    sel_bank;
    logic [DQ_W-1:0]    sel_dq;
    logic               sel_dq_oe;
    logic               sel_end;

    // Candidate at search position k: rr_ptr+1+k wrapped into 0..NUM_CH-1.
    function automatic logic [2:0] rr_index(input logic [2:0] ptr, input int k);
        int sum;
        sum = int'(ptr) + 1 + k;
        if (sum >= NUM_CH) sum = sum - NUM_CH;
        return 3'(sum);
    endfunction

    // Winner search; the candidate order alone distinguishes round-robin from fixed priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = (RR_EN != 0) ? rr_index(rr_ptr, k) : 3'(k);
            for (int j = 0; j < NUM_CH; j++) begin
                if (!win_found && cand == 3'(j) && bus.ch_req[j]) begin
                    win_found = 1'b1;
                    win_idx   = cand;
                end
            end
        end
    end

    // Granted-channel slice, selected with constant indices so grant_id width never matters.
    always_comb begin
        sel_cmd   = '0;
        sel_addr  = '0;
        sel_bank  = '0;
        sel_dq    = '0;
        sel_dq_oe = 1'b0;
        sel_end   = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant_id == 3'(i)) begin
                sel_cmd   = bus.ch_cmd[4*i +: 4];
                sel_addr  = bus.ch_addr[ADDR_W*i +: ADDR_W];
                sel_bank  = bus.ch_bank[BA_W*i +: BA_W];
                sel_dq    = bus.ch_dq[DQ_W*i +: DQ_W];
                sel_dq_oe = bus.ch_dq_oe[i];
                sel_end   = bus.ch_end[i];
            end
        end
    end

    // The forcing edge is the one on which the timer would reach TIMEOUT,
    // so an engine that never ends holds the bus for exactly TIMEOUT cycles.
    assign wd_expire = (TIMEOUT != 0) && (timer == TMR_W'(TIMEOUT - 1));

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        next_state  = state;
        ref_en_nxt  = 1'b0;
        ch_en_nxt   = '0;
        grant_nxt   = grant_id;
        rr_ptr_nxt  = rr_ptr;
        timeout_hit = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.init_end) next_state = ARBIT;
            end
            ARBIT: begin
                if (bus.ref_req) begin
                    ref_en_nxt = 1'b1;
                    next_state = AREF;
                end else if (win_found) begin
                    ch_en_nxt  = NUM_CH'(1) << win_idx;
                    grant_nxt  = win_idx;
                    rr_ptr_nxt = win_idx;
                    next_state = ACCESS;
                end
            end
            AREF: begin
                if (bus.ref_end) begin
                    next_state = ARBIT;
                end else if (wd_expire) begin
                    next_state  = ARBIT;
                    timeout_hit = 1'b1;
                end
            end
            ACCESS: begin
                // A real end pulse in the expiry cycle wins over the watchdog.
                if (sel_end) begin
                    next_state = ARBIT;
                end else if (wd_expire) begin
                    next_state  = ARBIT;
                    timeout_hit = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state       <= IDLE;
            ref_en      <= 1'b0;
            ch_en       <= '0;
            grant_id    <= '0;
            rr_ptr      <= 3'(NUM_CH - 1);
            timer       <= '0;
            err_timeout <= 1'b0;
        end else begin
            state       <= next_state;
            ref_en      <= ref_en_nxt;
            ch_en       <= ch_en_nxt;
            grant_id    <= grant_nxt;
            rr_ptr      <= rr_ptr_nxt;
            timer       <= ((state == AREF || state == ACCESS) && next_state == state)
                           ? timer + 1'b1 : '0;
            err_timeout <= err_timeout | timeout_hit;
        end
    end

    always_comb begin
        bus.sd_cmd    = CMD_NOP;
        bus.sd_addr   = '0;
        bus.sd_bank   = '0;
        bus.sd_dq_out = '0;
        bus.sd_dq_oe  = 1'b0;
        unique case (state)
            IDLE: begin
                bus.sd_cmd  = bus.init_cmd;
                bus.sd_addr = bus.init_addr;
            end
            AREF: begin
                bus.sd_cmd  = bus.ref_cmd;
                bus.sd_addr = bus.ref_addr;
            end
            ACCESS: begin
                bus.sd_cmd    = sel_cmd;
                bus.sd_addr   = sel_addr;
                bus.sd_bank   = sel_bank;
                bus.sd_dq_out = sel_dq;
                bus.sd_dq_oe  = sel_dq_oe;
            end
            default: ;
        endcase
    end

    assign bus.ref_en      = ref_en;
    assign bus.ch_en       = ch_en;
    assign bus.grant_id    = grant_id;
    assign bus.busy        = (state == AREF) || (state == ACCESS);
    assign bus.err_timeout = err_timeout;

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed bench: a fixed-priority arbiter with a 15-cycle watchdog and a round-robin arbiter,
// both driven cycle by cycle with hand-computed expected bus values.
module tb_sdram_cmd_arbiter;

    localparam logic [3:0]  NOP       = 4'b0111;
    localparam logic [3:0]  INIT_CMD  = 4'b0010;
    localparam logic [12:0] INIT_ADDR = 13'h0400;
    localparam logic [3:0]  REF_CMD   = 4'b0001;
    localparam logic [12:0] REF_ADDR  = 13'h0abc;

    logic sclk;
    logic s_rst_n;
    int   n_checks;
    int   n_errors;

    sdram_cmd_arbiter_if #(.NUM_CH(4), .ADDR_W(13), .BA_W(2), .DQ_W(24)) bus_fp ();
    sdram_cmd_arbiter_if #(.NUM_CH(4), .ADDR_W(13), .BA_W(2), .DQ_W(24)) bus_rr ();

    sdram_cmd_arbiter #(
        .NUM_CH(4), .ADDR_W(13), .BA_W(2), .DQ_W(24), .RR_EN(0), .TIMEOUT(15)
    ) u_fp (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .bus     (bus_fp)
    );

    sdram_cmd_arbiter #(
        .NUM_CH(4), .ADDR_W(13), .BA_W(2), .DQ_W(24), .RR_EN(1), .TIMEOUT(1023)
    ) u_rr (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .bus     (bus_rr)
    );

    // Data-path inputs are common to both arbiters.
    assign bus_rr.init_cmd  = bus_fp.init_cmd;
    assign bus_rr.init_addr = bus_fp.init_addr;
    assign bus_rr.ref_cmd   = bus_fp.ref_cmd;
    assign bus_rr.ref_addr  = bus_fp.ref_addr;
    assign bus_rr.ch_cmd    = bus_fp.ch_cmd;
    assign bus_rr.ch_addr   = bus_fp.ch_addr;
    assign bus_rr.ch_bank   = bus_fp.ch_bank;
    assign bus_rr.ch_dq_oe  = bus_fp.ch_dq_oe;
    assign bus_rr.ch_dq     = bus_fp.ch_dq;

    initial begin
        sclk = 1'b0;
        forever #5 sclk = ~sclk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        s_rst_n  = 1'b1;

        bus_fp.init_cmd  = INIT_CMD;
        bus_fp.init_addr = INIT_ADDR;
        bus_fp.ref_cmd   = REF_CMD;
        bus_fp.ref_addr  = REF_ADDR;
        bus_fp.ch_cmd    = 16'h2354;   // ch0=4 ch1=5 ch2=3 ch3=2
        bus_fp.ch_addr   = {13'h103, 13'h102, 13'h101, 13'h100};
        bus_fp.ch_bank   = {2'd3, 2'd2, 2'd1, 2'd0};
        bus_fp.ch_dq_oe  = 4'b0101;
        bus_fp.ch_dq     = {24'h444444, 24'h333333, 24'h222222, 24'h111111};
        bus_fp.init_end = 1'b0; bus_fp.ref_req = 1'b0; bus_fp.ref_end = 1'b0;
        bus_fp.ch_req   = '0;   bus_fp.ch_end  = '0;
        bus_rr.init_end = 1'b0; bus_rr.ref_req = 1'b0; bus_rr.ref_end = 1'b0;
        bus_rr.ch_req   = '0;   bus_rr.ch_end  = '0;

        #1 s_rst_n = 1'b0;
        #1;
        check("rst_ch_en",    32'(bus_fp.ch_en),       32'h0);
        check("rst_ref_en",   32'(bus_fp.ref_en),      32'h0);
        check("rst_grant_id", 32'(bus_fp.grant_id),    32'h0);
        check("rst_busy",     32'(bus_fp.busy),        32'h0);
        check("rst_err",      32'(bus_fp.err_timeout), 32'h0);
        check("rst_sd_cmd",   32'(bus_fp.sd_cmd),      32'(INIT_CMD));
        #10 s_rst_n = 1'b1;

        // IDLE holds the init sequencer on the bus until init_end.
        repeat (9) tick();
        check("idle_sd_cmd",  32'(bus_fp.sd_cmd),  32'(INIT_CMD));
        check("idle_sd_addr", 32'(bus_fp.sd_addr), 32'(INIT_ADDR));
        bus_fp.init_end = 1'b1;
        tick();
        check("arbit_nop",  32'(bus_fp.sd_cmd),  32'(NOP));
        check("arbit_addr", 32'(bus_fp.sd_addr), 32'h0);

        // Fixed priority: lowest index of 1010 is ch1.
        bus_fp.ch_req = 4'b1010;
        tick();
        check("fp_grant1_en",   32'(bus_fp.ch_en),    32'h2);
        check("fp_grant1_id",   32'(bus_fp.grant_id), 32'h1);
        check("fp_grant1_cmd",  32'(bus_fp.sd_cmd),   32'h5);
        check("fp_grant1_bank", 32'(bus_fp.sd_bank),  32'h1);
        check("fp_grant1_oe",   32'(bus_fp.sd_dq_oe), 32'h0);
        tick();
        check("fp_pulse_width", 32'(bus_fp.ch_en), 32'h0);
        bus_fp.ch_end = 4'b0010; bus_fp.ch_req = 4'b1000;
        tick();
        bus_fp.ch_end = '0;
        check("fp_end1_busy", 32'(bus_fp.busy),   32'h0);
        check("fp_end1_nop",  32'(bus_fp.sd_cmd), 32'(NOP));
        tick();
        check("fp_grant3_en", 32'(bus_fp.ch_en),    32'h8);
        check("fp_grant3_id", 32'(bus_fp.grant_id), 32'h3);
        check("fp_grant3_ad", 32'(bus_fp.sd_addr),  32'h103);

        // Foreign ch_end and a stray ref_end during ACCESS are ignored.
        bus_fp.ch_req = '0;
        bus_fp.ch_end = 4'b0010; bus_fp.ref_end = 1'b1;
        tick();
        bus_fp.ch_end = '0; bus_fp.ref_end = 1'b0;
        check("fp_foreign_end", 32'(bus_fp.busy), 32'h1);
        bus_fp.ch_end = 4'b1000;
        tick();
        bus_fp.ch_end = '0;
        check("fp_end3_busy", 32'(bus_fp.busy), 32'h0);

        // ch0 write burst: DQ follows ch0 throughout, request dropped in the grant cycle.
        bus_fp.ch_req = 4'b0001;
        tick();
        bus_fp.ch_req = '0;
        check("fp_ch0_en",   32'(bus_fp.ch_en),     32'h1);
        check("fp_ch0_oe",   32'(bus_fp.sd_dq_oe),  32'h1);
        check("fp_ch0_dq",   32'(bus_fp.sd_dq_out), 32'h111111);
        bus_fp.ch_end = 4'b1000;
        tick();
        bus_fp.ch_end = '0;
        check("fp_ch0_hold", 32'(bus_fp.busy),      32'h1);
        check("fp_ch0_oe2",  32'(bus_fp.sd_dq_oe),  32'h1);
        bus_fp.ch_dq[23:0] = 24'habcdef;
        #1;
        check("fp_ch0_dq2",  32'(bus_fp.sd_dq_out), 32'habcdef);
        bus_fp.ch_dq[23:0] = 24'h111111;
        bus_fp.ch_end = 4'b0001;
        tick();
        bus_fp.ch_end = '0;
        check("fp_ch0_done", 32'(bus_fp.busy), 32'h0);

        // End pulse in the watchdog's last cycle wins: no error.
        bus_fp.ch_req = 4'b0100;
        tick();
        bus_fp.ch_req = '0;
        repeat (14) tick();
        check("wd_race_busy", 32'(bus_fp.busy), 32'h1);
        bus_fp.ch_end = 4'b0100;
        tick();
        bus_fp.ch_end = '0;
        check("wd_race_arbit", 32'(bus_fp.busy),        32'h0);
        check("wd_race_err",   32'(bus_fp.err_timeout), 32'h0);

        // Client never ends: forced back to ARBIT 15 cycles after entry.
        bus_fp.ch_req = 4'b0100;
        tick();
        bus_fp.ch_req = '0;
        repeat (14) tick();
        check("wd_last_busy", 32'(bus_fp.busy),        32'h1);
        check("wd_last_err",  32'(bus_fp.err_timeout), 32'h0);
        tick();
        check("wd_fire_busy", 32'(bus_fp.busy),        32'h0);
        check("wd_fire_err",  32'(bus_fp.err_timeout), 32'h1);
        check("wd_fire_nop",  32'(bus_fp.sd_cmd),      32'(NOP));
        repeat (3) tick();
        check("wd_err_sticky", 32'(bus_fp.err_timeout), 32'h1);

        // Round-robin: all requesting, 5-cycle accesses, one ARBIT cycle between grants.
        bus_rr.init_end = 1'b1;
        tick();
        check("rr_arbit_nop", 32'(bus_rr.sd_cmd), 32'(NOP));
        bus_rr.ch_req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            tick();
            check($sformatf("rr_grant%0d_en", n), 32'(bus_rr.ch_en),    32'(1 << (n % 4)));
            check($sformatf("rr_grant%0d_id", n), 32'(bus_rr.grant_id), 32'(n % 4));
            repeat (4) tick();
            bus_rr.ch_end = 4'(1 << (n % 4));
            tick();
            bus_rr.ch_end = '0;
            check($sformatf("rr_gap%0d_busy", n), 32'(bus_rr.busy), 32'h0);
        end

        // Refresh beats ch2, leaves rr_ptr at 0, so ch2 (not ch0) is next.
        bus_rr.ref_req = 1'b1; bus_rr.ch_req = 4'b0101;
        tick();
        bus_rr.ref_req = 1'b0;
        check("rr_ref_en",   32'(bus_rr.ref_en),  32'h1);
        check("rr_ref_ch",   32'(bus_rr.ch_en),   32'h0);
        check("rr_ref_cmd",  32'(bus_rr.sd_cmd),  32'(REF_CMD));
        check("rr_ref_addr", 32'(bus_rr.sd_addr), 32'(REF_ADDR));
        tick();
        check("rr_ref_pulse", 32'(bus_rr.ref_en), 32'h0);
        bus_rr.ref_end = 1'b1;
        tick();
        bus_rr.ref_end = 1'b0;
        check("rr_ref_done", 32'(bus_rr.busy), 32'h0);
        tick();
        check("rr_after_ref_en", 32'(bus_rr.ch_en),    32'h4);
        check("rr_after_ref_id", 32'(bus_rr.grant_id), 32'h2);

        // Refresh request during ACCESS does not preempt.
        bus_rr.ch_req = '0; bus_rr.ref_req = 1'b1;
        tick();
        check("rr_nopre_busy", 32'(bus_rr.busy),   32'h1);
        check("rr_nopre_ref",  32'(bus_rr.ref_en), 32'h0);
        check("rr_nopre_cmd",  32'(bus_rr.sd_cmd), 32'h3);
        bus_rr.ch_end = 4'b0100;
        tick();
        bus_rr.ch_end = '0;
        tick();
        bus_rr.ref_req = 1'b0;
        check("rr_late_ref", 32'(bus_rr.ref_en), 32'h1);
        bus_rr.ref_end = 1'b1;
        tick();
        bus_rr.ref_end = 1'b0;

        // Asynchronous reset in the middle of an access.
        bus_fp.ch_req = 4'b0010;
        tick();
        bus_fp.ch_req = '0;
        check("ar_pre_id", 32'(bus_fp.grant_id), 32'h1);
        #2 s_rst_n = 1'b0;
        #1;
        check("ar_busy", 32'(bus_fp.busy),        32'h0);
        check("ar_id",   32'(bus_fp.grant_id),    32'h0);
        check("ar_err",  32'(bus_fp.err_timeout), 32'h0);
        check("ar_cmd",  32'(bus_fp.sd_cmd),      32'(INIT_CMD));
        tick();
        check("ar_hold_cmd", 32'(bus_fp.sd_cmd), 32'(INIT_CMD));
        s_rst_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
